// File: rtl/next_pc_unit.sv
// next_pc_unit
// Next-PC generator for the fetch stage. It predicts the next fetch address
// from a direct-mapped BTB with 2-bit saturating counters, trains the BTB
// from execute-stage resolutions, and redirects fetch on a mispredict. A
// redirect that arrives while fetch is stalled is held until the stall ends.
//
// Ports
//   CLK, RESET        : clock, synchronous active-high reset
//   PCF, StallF       : current fetch PC and fetch stall
//   ResolveE, PCE, TakenE, TargetE, PredTakenE, PredTargetE
//                     : execute-stage branch resolution and its carried prediction
//   PC                : next fetch address (to the fetch PC register)
//   PredTakenF, PredTargetF : prediction for PCF
//   RedirectE         : mispredict detected this cycle
//   BranchCount, MispredictCount : 32-bit wrapping event counters
module next_pc_unit #(
  parameter int SIZE    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] PCF,
  input  logic            StallF,
  input  logic            ResolveE,
  input  logic [SIZE-1:0] PCE,
  input  logic            TakenE,
  input  logic [SIZE-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [SIZE-1:0] PredTargetE,
  output logic [SIZE-1:0] PC,
  output logic            PredTakenF,
  output logic [SIZE-1:0] PredTargetF,
  output logic            RedirectE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = SIZE - IDX - 2;
  localparam logic [SIZE-1:0] FOUR = SIZE'(32'd4);

  // BTB storage
  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [SIZE-1:0] tgt_q   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];

  // Pending redirect and event counters
  logic            pend_q,  pend_d;
  logic [SIZE-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mis_cnt_q, mis_cnt_d;

  // Lookup-side decode
  logic [IDX-1:0]  f_idx_s;
  logic [TAGW-1:0] f_tag_s;
  logic            f_hit_s;
  logic [SIZE-1:0] pcf_plus4_s;

  // Resolve-side decode
  logic [IDX-1:0]  e_idx_s;
  logic [TAGW-1:0] e_tag_s;
  logic            e_hit_s;
  logic            mis_s;
  logic [SIZE-1:0] correct_pc_s;

  // Single-entry write port for the BTB
  logic            wr_en_s;
  logic [TAGW-1:0] wr_tag_s;
  logic [SIZE-1:0] wr_tgt_s;
  logic [1:0]      wr_ctr_s;

  assign f_idx_s     = PCF[IDX+1:2];
  assign f_tag_s     = PCF[SIZE-1:IDX+2];
  assign pcf_plus4_s = PCF + FOUR;
  assign e_idx_s     = PCE[IDX+1:2];
  assign e_tag_s     = PCE[SIZE-1:IDX+2];

  // Lookup: the array read uses pre-update contents within the same cycle
  always_comb begin
    f_hit_s     = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    PredTakenF  = f_hit_s && ctr_q[f_idx_s][1];
    if (f_hit_s) begin
      PredTargetF = tgt_q[f_idx_s];
    end else begin
      PredTargetF = pcf_plus4_s;
    end
  end

  // Mispredict detection and the architecturally correct next PC
  always_comb begin
    mis_s = ResolveE && ((TakenE != PredTakenE) ||
                         (TakenE && (PredTargetE != TargetE)));
    RedirectE = mis_s;
    if (TakenE) begin
      correct_pc_s = TargetE;
    end else begin
      correct_pc_s = PCE + FOUR;
    end
  end

  // Next-PC selection: mispredict beats a held redirect, which beats prediction
  always_comb begin
    if (mis_s) begin
      PC = correct_pc_s;
    end else if (pend_q) begin
      PC = pend_pc_q;
    end else if (PredTakenF) begin
      PC = PredTargetF;
    end else begin
      PC = pcf_plus4_s;
    end
  end

  // Pending redirect: newest mispredict under stall wins; cleared once unstalled
  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (mis_s && StallF) begin
      pend_d    = 1'b1;
      pend_pc_d = correct_pc_s;
    end else if (!StallF) begin
      pend_d    = 1'b0;
    end else begin
      pend_d    = pend_q;
    end
  end

  // BTB training: hits adjust the counter, taken misses allocate over the occupant
  always_comb begin
    e_hit_s  = valid_q[e_idx_s] && (tag_q[e_idx_s] == e_tag_s);
    wr_en_s  = 1'b0;
    wr_tag_s = e_tag_s;
    wr_tgt_s = tgt_q[e_idx_s];
    wr_ctr_s = ctr_q[e_idx_s];
    if (ResolveE && e_hit_s) begin
      wr_en_s = 1'b1;
      if (TakenE) begin
        wr_tgt_s = TargetE;
        if (ctr_q[e_idx_s] != 2'b11) begin
          wr_ctr_s = ctr_q[e_idx_s] + 2'b01;
        end else begin
          wr_ctr_s = 2'b11;
        end
      end else begin
        if (ctr_q[e_idx_s] != 2'b00) begin
          wr_ctr_s = ctr_q[e_idx_s] - 2'b01;
        end else begin
          wr_ctr_s = 2'b00;
        end
      end
    end else if (ResolveE && TakenE) begin
      wr_en_s  = 1'b1;
      wr_tgt_s = TargetE;
      wr_ctr_s = 2'b10;
    end else begin
      wr_en_s  = 1'b0;
    end
  end

  // Event counters wrap naturally at 32 bits
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (ResolveE) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (mis_s) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // BTB array state; reset discards any update presented in the same cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en_s) begin
      valid_q[e_idx_s] <= 1'b1;
      tag_q[e_idx_s]   <= wr_tag_s;
      tgt_q[e_idx_s]   <= wr_tgt_s;
      ctr_q[e_idx_s]   <= wr_ctr_s;
    end
  end

  // Pending redirect and counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      branch_cnt_q <= 32'd0;
      mis_cnt_q    <= 32'd0;
    end else begin
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic        CLK = 1'b0;
  logic        RESET, StallF, ResolveE, TakenE, PredTakenE;
  logic [31:0] PCF, PCE, TargetE, PredTargetE;
  logic [31:0] PC, PredTargetF, BranchCount, MispredictCount;
  logic        PredTakenF, RedirectE;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_bc, m_mc;

  always #5 CLK = ~CLK;

  next_pc_unit #(.SIZE(32), .ENTRIES(ENTRIES)) dut (
    .CLK(CLK), .RESET(RESET), .PCF(PCF), .StallF(StallF),
    .ResolveE(ResolveE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .PC(PC), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .RedirectE(RedirectE), .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a / 32'd4) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] a);
    return a / (32'd4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_pend = 1'b0; m_pend_pc = 32'd0; m_bc = 32'd0; m_mc = 32'd0;
  endtask

  task automatic idle();
    RESET = 1'b0; StallF = 1'b0; ResolveE = 1'b0; TakenE = 1'b0;
    PredTakenE = 1'b0; PCE = 32'd0; TargetE = 32'd0; PredTargetE = 32'd0;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit ptaken, input logic [31:0] ptgt);
    ResolveE = 1'b1; PCE = pc; TakenE = taken; TargetE = tgt;
    PredTakenE = ptaken; PredTargetE = ptgt;
  endtask

  // Check all outputs against the model, clock once, then advance the model.
  task automatic step();
    int          fi, ei;
    bit          hit, ptk, mis, ehit;
    logic [31:0] ptg, corr, epc;
    #1;
    fi  = midx(PCF);
    hit = m_valid[fi] && (m_tag[fi] == mtag(PCF));
    ptk = hit && (m_ctr[fi] >= 2);
    ptg = hit ? m_tgt[fi] : PCF + 32'd4;
    mis = ResolveE && ((TakenE != PredTakenE) || (TakenE && (PredTargetE != TargetE)));
    corr = TakenE ? TargetE : PCE + 32'd4;
    if (mis)         epc = corr;
    else if (m_pend) epc = m_pend_pc;
    else if (ptk)    epc = ptg;
    else             epc = PCF + 32'd4;
    chk("pc", PC, epc);
    chk("pred_taken", {31'd0, PredTakenF}, {31'd0, ptk});
    chk("pred_target", PredTargetF, ptg);
    chk("redirect", {31'd0, RedirectE}, {31'd0, mis});
    chk("branch_count", BranchCount, m_bc);
    chk("mispredict_count", MispredictCount, m_mc);
    @(posedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
      if (mis && StallF) begin m_pend = 1'b1; m_pend_pc = corr; end
      else if (!StallF) m_pend = 1'b0;
      if (ResolveE) begin
        m_bc = m_bc + 32'd1;
        ei   = midx(PCE);
        ehit = m_valid[ei] && (m_tag[ei] == mtag(PCE));
        if (ehit && TakenE) begin
          m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
          m_tgt[ei] = TargetE;
        end else if (ehit) begin
          m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
        end else if (TakenE) begin
          m_valid[ei] = 1'b1; m_tag[ei] = mtag(PCE); m_tgt[ei] = TargetE; m_ctr[ei] = 2;
        end
      end
      if (mis) m_mc = m_mc + 32'd1;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    model_reset();
    idle();
    PCF = 32'hFFFF_FFFC;
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Reset, no resolves
    RESET = 1'b1; PCF = 32'hFFFF_FFFC;
    #1; chk("reset_pc", PC, 32'h0000_0000);
    chk("reset_pred", {31'd0, PredTakenF}, 32'd0);
    chk("reset_bcount", BranchCount, 32'd0);
    chk("reset_mcount", MispredictCount, 32'd0);
    step();

    // Cold taken branch
    idle(); PCF = 32'h0; resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1; chk("cold_redirect", {31'd0, RedirectE}, 32'd1); chk("cold_pc", PC, 32'h100);
    step();
    idle(); PCF = 32'h40;
    #1; chk("cold_pred", {31'd0, PredTakenF}, 32'd1); chk("cold_ptgt", PredTargetF, 32'h100);
    chk("cold_mcount", MispredictCount, 32'd1);
    step();

    // Training and saturation (entry allocated at 10, two more takens saturate at 11)
    for (int k = 0; k < 2; k++) begin
      idle(); PCF = 32'h84; resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      step();
    end
    idle(); PCF = 32'h84; resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    #1; chk("nt_redirect", {31'd0, RedirectE}, 32'd1); chk("nt_pc", PC, 32'h44);
    step();
    idle(); PCF = 32'h40;
    #1; chk("still_taken", {31'd0, PredTakenF}, 32'd1);
    step();
    idle(); PCF = 32'h84; resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    step();
    idle(); PCF = 32'h40;
    #1; chk("trained_nt", {31'd0, PredTakenF}, 32'd0);
    step();

    // Aliasing: 0x440 shares index 0 with 0x40
    idle(); PCF = 32'h84; resolve(32'h440, 1'b1, 32'h500, 1'b0, 32'h444);
    step();
    idle(); PCF = 32'h40;
    #1; chk("alias_pred", {31'd0, PredTakenF}, 32'd0); chk("alias_pc", PC, 32'h44);
    step();

    // Redirect under stall, then a newer mispredict overrides it
    idle(); PCF = 32'h84; StallF = 1'b1; resolve(32'h60, 1'b1, 32'h200, 1'b0, 32'h64);
    #1; chk("stall_pc0", PC, 32'h200);
    step();
    for (int k = 1; k < 3; k++) begin
      idle(); PCF = 32'h84; StallF = 1'b1;
      #1; chk("stall_pc_hold", PC, 32'h200);
      step();
    end
    idle(); PCF = 32'h84; StallF = 1'b1; resolve(32'h70, 1'b1, 32'h300, 1'b0, 32'h74);
    #1; chk("stall_newest", PC, 32'h300);
    step();
    idle(); PCF = 32'h84;
    #1; chk("stall_release", PC, 32'h300);
    step();
    idle(); PCF = 32'h300;
    #1; chk("after_stall", PC, 32'h304);
    step();

    // Fetch address wrap
    idle(); PCF = 32'hFFFF_FFFC;
    #1; chk("wrap_pc", PC, 32'h0);
    step();

    // Reset mid-operation drops pending redirect, BTB and the same-cycle update
    idle(); PCF = 32'h84; StallF = 1'b1; resolve(32'h90, 1'b1, 32'h700, 1'b0, 32'h94);
    step();
    idle(); RESET = 1'b1; PCF = 32'h84; StallF = 1'b1; resolve(32'h60, 1'b1, 32'h800, 1'b0, 32'h64);
    step();
    idle(); PCF = 32'h60; StallF = 1'b1;
    #1; chk("rst_mid_pc", PC, 32'h64); chk("rst_mid_bcount", BranchCount, 32'd0);
    chk("rst_mid_mcount", MispredictCount, 32'd0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      RESET  = ($urandom_range(0, 99) == 0);
      StallF = ($urandom_range(0, 3) == 0);
      PCF    = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        PCE         = rand_addr();
        ResolveE    = 1'b1;
        TakenE      = $urandom_range(0, 1);
        TargetE     = rand_addr();
        PredTakenE  = $urandom_range(0, 1);
        PredTargetE = ($urandom_range(0, 2) == 0) ? rand_addr() : TargetE;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Next-PC generator for the pipelined core's fetch stage. It sits directly upstream of the fetch PC register and drives that register's `PC` input every cycle. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and predicts the next fetch address from `PCF`. It applies execute-stage branch resolutions, redirecting fetch on a mispredict and holding any redirect that arrives while fetch is stalled until fetch resumes.

## Interface
- `SIZE`, default 32: address width.
- `ENTRIES`, default 16: number of BTB entries; must be a power of two ≥ 2.
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `PCF`  in  SIZE: current fetch PC, from the fetch PC register.
- `StallF`  in  1: fetch stall, from the hazard unit.
- `ResolveE`  in  1: a branch or jump resolves in execute this cycle.
- `PCE`  in  SIZE: PC of the resolving instruction.
- `TakenE`  in  1: actual outcome.
- `TargetE`  in  SIZE: actual target.
- `PredTakenE`  in  1: prediction made for this instruction, carried down the pipe.
- `PredTargetE`  in  SIZE: predicted target carried down the pipe.
- `PC`  out  SIZE: next fetch address, to the fetch PC register.
- `PredTakenF`  out  1: prediction for `PCF`, to be piped along.
- `PredTargetF`  out  SIZE: predicted target for `PCF`.
- `RedirectE`  out  1: mispredict detected; the hazard unit flushes D and E.
- `BranchCount`  out  32: resolved branches since reset.
- `MispredictCount`  out  32: mispredicts since reset.

## Operation
- **Index and tag.**
  - IDX = log2(ENTRIES).
  - Index = `addr[IDX+1:2]`.
  - Tag = `addr[SIZE-1:IDX+2]`.
  - Each entry holds valid, tag, target (SIZE bits) and a 2-bit counter.
- **Lookup (combinational).**
  - hit = valid & tag match for `PCF`.
  - `PredTakenF` = hit & ctr[1].
  - `PredTargetF` = entry target when hit, else `PCF`+4.
- **Mispredict (combinational).**
  - mis = `ResolveE` & ((`TakenE` != `PredTakenE`) | (`TakenE` & `PredTargetE` != `TargetE`)).
  - `RedirectE` = mis.
  - Correct PC = `TargetE` if `TakenE`, else `PCE`+4.
- **Next-PC priority for `PC`:**
  1. mis → correct PC.
  2. pending redirect → latched PC.
  3. `PredTakenF` → `PredTargetF`.
  4. otherwise → `PCF`+4.
- **Pending redirect.**
  - Set at a rising edge when mis & `StallF`; latches the correct PC.
  - Cleared at the first rising edge with `StallF` low and no new mis.
  - A new mis always overwrites the pending value (newest wins).
- **BTB update (rising edge, when `ResolveE`; independent of `StallF`).**
  - Hit on `PCE`, taken: ctr increments, saturating at 11; target := `TargetE`.
  - Hit on `PCE`, not taken: ctr decrements, saturating at 00; target unchanged.
  - Miss on `PCE`, taken: allocate. valid := 1, tag, target := `TargetE`, ctr := 10. This replaces any occupant.
  - Miss on `PCE`, not taken: no change.
- **Counters.**
  - `BranchCount` +1 per `ResolveE`.
  - `MispredictCount` +1 per mis.
  - Both wrap modulo 2^32.
- **Arithmetic.** All +4 additions are SIZE-bit, wrapping. `PCF`=FFFF_FFFC gives `PC`=0000_0000.

## Timing
- **Reset.**
  - All valid bits 0, counters 01, targets 0, pending cleared.
  - `BranchCount` and `MispredictCount` = 0.
  - Outputs during/after reset are purely combinational from the cleared state: `PredTakenF`=0, `PredTargetF`=`PC`=`PCF`+4, `RedirectE`=0 unless `ResolveE`.
  - With the fetch PC register's reset value FFFF_FFFC, the first fetch address is 0.
- **Reset mid-operation.** Reset drops any pending redirect and all BTB contents in the same edge. An update or count in that cycle is discarded.
- **Latency.**
  - Prediction and redirect: 0 cycles (combinational).
  - A BTB update becomes visible to lookup the cycle after the update edge.
- **Same-index read/update in one cycle.** Lookup sees pre-update contents.
- **Redirect during stall.** `PC` shows the correct PC in the mis cycle. From the next cycle on, the pending path holds it until `StallF` low is sampled.

## Test plan
- **Reset, then no resolves.** `RESET`=1 one cycle, `PCF`=FFFF_FFFC → `PC`=0000_0000; `PredTakenF`=0; both counters 0.
- **Cold taken branch.**
  - Resolve `PCE`=0x40, `TakenE`=1, `TargetE`=0x100, `PredTakenE`=0 → `RedirectE`=1, `PC`=0x100, `MispredictCount`=1.
  - Next cycle with `PCF`=0x40 → `PredTakenF`=1, `PredTargetF`=0x100.
- **Counter saturation and training.**
  - Three taken resolves at 0x40, then one not-taken: the not-taken produces `RedirectE`=1 with `PC`=0x44.
  - After it, `PCF`=0x40 still predicts taken (ctr 11→10).
  - A second not-taken (ctr 10→01) → `PredTakenF`=0.
- **Aliasing.** With ENTRIES=16, a taken branch at 0x440 replaces the 0x40 entry → `PCF`=0x40 misses, `PC`=0x44.
- **Redirect under stall.**
  - mis to 0x200 with `StallF`=1 held 3 cycles → `PC`=0x200 every cycle.
  - After `StallF` falls, `PC` resumes from `PCF`+4 or the prediction.
  - A second mis to 0x300 during the stall → `PC`=0x300.
- **Wrap.** Preload the counters via 2^32 resolves (or force them) → `BranchCount` wraps to 0. `PCF`=FFFF_FFFC → `PC`=0.
